// File: rtl/logic_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_pkg
// Description : Shared definitions for the pipelined logic unit. Holds the
//               function-select encoding and the default datapath width.
//               The low two opcode bits keep the legacy {s1,s0} encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_unit_pkg;

   localparam int c_default_width = 8;

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_XOR  = 3'b001,
      OP_OR   = 3'b010,
      OP_NOT  = 3'b011,
      OP_NAND = 3'b100,
      OP_NOR  = 3'b101,
      OP_XNOR = 3'b110,
      OP_PASS = 3'b111
   } op_e;

endpackage
`default_nettype wire

// File: rtl/logic_op_core.sv
`default_nettype none
// ============================================================================
// Module      : logic_op_core
// Description : Purely combinational bitwise function unit.
//               Ports: i_a, i_b  - WIDTH-bit operands
//                      i_op      - function select (op_e)
//                      o_result  - WIDTH-bit result (no carry, no extension)
// Revision    : 1.0 - initial release
// ============================================================================
module logic_op_core
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = c_default_width
)(
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  op_e              i_op,
   output logic [WIDTH-1:0] o_result
);

   always_comb begin
      o_result = '0;
      case (i_op)
         OP_AND  : o_result = i_a & i_b;
         OP_XOR  : o_result = i_a ^ i_b;
         OP_OR   : o_result = i_a | i_b;
         OP_NOT  : o_result = ~i_a;
         OP_NAND : o_result = ~(i_a & i_b);
         OP_NOR  : o_result = ~(i_a | i_b);
         OP_XNOR : o_result = ~(i_a ^ i_b);
         OP_PASS : o_result = i_a;
         default : o_result = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_pipe
// Description : Two-stage pipelined eight-function bitwise logic unit with
//               valid/ready handshakes on input and output.
//               S1 holds the accepted operands, S2 holds the registered
//               result with zero/parity flags.
//               Optional accumulator (build macro LOGICU_ACC_EN) can replace
//               operand B and capture results.
//               Ports: clk, rst (sync, active-high)
//                      in_valid/in_ready, a, b, op, use_acc, acc_wr, acc_clr
//                      out_valid/out_ready, out, zero, parity
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = c_default_width
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             use_acc,
   input  logic             acc_wr,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             parity
);

   // Pipeline control
   logic             w_adv1;
   logic             w_adv2;
   logic             w_accept;

   // S1 operand stage
   logic             r_s1_valid_q, w_s1_valid_d;
   logic [WIDTH-1:0] r_s1_a_q,     w_s1_a_d;
   logic [WIDTH-1:0] r_s1_b_q,     w_s1_b_d;
   op_e              r_s1_op_q,    w_s1_op_d;

   // S2 result stage
   logic             r_out_valid_q, w_out_valid_d;
   logic [WIDTH-1:0] r_out_q,       w_out_d;
   logic             r_zero_q,      w_zero_d;
   logic             r_parity_q,    w_parity_d;

   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH-1:0] w_result;

   // A stage may advance when the stage after it is empty or draining.
   assign w_adv2   = !r_out_valid_q | out_ready;
   assign w_adv1   = !r_s1_valid_q | w_adv2;
   assign in_ready = w_adv1 & !rst;
   assign w_accept = in_valid & in_ready;

`ifdef LOGICU_ACC_EN
   logic             r_s1_use_acc_q, w_s1_use_acc_d;
   logic             r_s1_acc_wr_q,  w_s1_acc_wr_d;
   logic [WIDTH-1:0] r_acc_q,        w_acc_d;

   // Accumulator is sampled at the S1->S2 edge, so a back-to-back beat sees
   // the result written by the beat directly ahead of it.
   assign w_b_eff = r_s1_use_acc_q ? r_acc_q : r_s1_b_q;

   always_comb begin
      w_s1_use_acc_d = r_s1_use_acc_q;
      w_s1_acc_wr_d  = r_s1_acc_wr_q;
      if (w_adv1 && w_accept) begin
         w_s1_use_acc_d = use_acc;
         w_s1_acc_wr_d  = acc_wr;
      end
   end

   // Clear wins over a simultaneous write and ignores the handshake.
   always_comb begin
      w_acc_d = r_acc_q;
      if (acc_clr) begin
         w_acc_d = '0;
      end else if (w_adv2 && r_s1_valid_q && r_s1_acc_wr_q) begin
         w_acc_d = w_result;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_use_acc_q <= 1'b0;
         r_s1_acc_wr_q  <= 1'b0;
         r_acc_q        <= '0;
      end else begin
         r_s1_use_acc_q <= w_s1_use_acc_d;
         r_s1_acc_wr_q  <= w_s1_acc_wr_d;
         r_acc_q        <= w_acc_d;
      end
   end
`else
   // Accumulator controls remain on the boundary but have no effect.
   logic w_unused_acc_ctrl;
   assign w_unused_acc_ctrl = use_acc ^ acc_wr ^ acc_clr;
   assign w_b_eff           = r_s1_b_q;
`endif

   logic_op_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .i_a      (r_s1_a_q),
      .i_b      (w_b_eff),
      .i_op     (r_s1_op_q),
      .o_result (w_result)
   );

   always_comb begin
      w_s1_valid_d = r_s1_valid_q;
      w_s1_a_d     = r_s1_a_q;
      w_s1_b_d     = r_s1_b_q;
      w_s1_op_d    = r_s1_op_q;
      if (w_adv1) begin
         w_s1_valid_d = w_accept;
         if (w_accept) begin
            w_s1_a_d  = a;
            w_s1_b_d  = b;
            w_s1_op_d = op_e'(op);
         end
      end
   end

   // Result data only changes when a new beat lands in S2, so it stays put
   // while the consumer is stalling.
   always_comb begin
      w_out_valid_d = r_out_valid_q;
      w_out_d       = r_out_q;
      w_zero_d      = r_zero_q;
      w_parity_d    = r_parity_q;
      if (w_adv2) begin
         w_out_valid_d = r_s1_valid_q;
         if (r_s1_valid_q) begin
            w_out_d    = w_result;
            w_zero_d   = ~|w_result;
            w_parity_d = ^w_result;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid_q  <= 1'b0;
         r_s1_a_q      <= '0;
         r_s1_b_q      <= '0;
         r_s1_op_q     <= OP_AND;
         r_out_valid_q <= 1'b0;
         r_out_q       <= '0;
         r_zero_q      <= 1'b0;
         r_parity_q    <= 1'b0;
      end else begin
         r_s1_valid_q  <= w_s1_valid_d;
         r_s1_a_q      <= w_s1_a_d;
         r_s1_b_q      <= w_s1_b_d;
         r_s1_op_q     <= w_s1_op_d;
         r_out_valid_q <= w_out_valid_d;
         r_out_q       <= w_out_d;
         r_zero_q      <= w_zero_d;
         r_parity_q    <= w_parity_d;
      end
   end

   assign out_valid = r_out_valid_q;
   assign out       = r_out_q;
   assign zero      = r_zero_q;
   assign parity    = r_parity_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_pipe
// Description : Self-checking bench for logic_unit_pipe (WIDTH=8). A truth-
//               table model predicts each accepted beat; a scoreboard checks
//               results, flags, latency and output hold. Accumulator
//               expectations follow the LOGICU_ACC_EN build macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;
   import logic_unit_pkg::*;

`ifdef LOGICU_ACC_EN
   localparam bit c_acc_en = 1'b1;
`else
   localparam bit c_acc_en = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [2:0] op = '0;
   logic       use_acc = 1'b0;
   logic       acc_wr = 1'b0;
   logic       acc_clr = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out;
   logic       zero;
   logic       parity;

   logic_unit_pipe #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .use_acc(use_acc), .acc_wr(acc_wr),
      .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .zero(zero), .parity(parity)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] res;
      int         acc_cyc;
      bit         lat;
   } exp_t;

   exp_t       q[$];
   logic [7:0] m_acc = '0;

   // Truth table per op, indexed by {a_bit, b_bit}.
   logic [3:0] tt [0:7] = '{4'b1000, 4'b0110, 4'b1110, 4'b0011,
                            4'b0111, 4'b0001, 4'b1001, 4'b1100};

   function automatic logic [7:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                        input logic [2:0] mop);
      logic [7:0] r;
      logic [3:0] t;
      t = tt[mop];
      for (int i = 0; i < 8; i++) r[i] = t[{ma[i], mb[i]}];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Scoreboard: compares every output handshake, latency of fresh beats,
   // and hold of result/flags while stalled.
   bit         stall_prev = 1'b0;
   logic [9:0] held;
   exp_t       e;
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) chk("hold_out", {out, zero, parity}, held);
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_out", out_valid, 1'b0);
            end else begin
               e = q[0];
               if (!stall_prev && e.lat) chk("latency", cyc, e.acc_cyc + 1);
               if (out_ready) begin
                  void'(q.pop_front());
                  chk("out", out, e.res);
                  chk("zero", zero, (e.res == 8'h00));
                  chk("parity", parity, ^e.res);
               end
            end
         end
         stall_prev = out_valid & !out_ready;
         held = {out, zero, parity};
      end
   end

   // Presents one beat and returns just after the edge that accepted it,
   // with in_valid still high (caller chains another send or calls idle).
   task automatic send(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] iop,
                       input logic iua, input logic iaw, input bit lat,
                       input bit has_lit, input logic [7:0] lit);
      int n;
      logic [7:0] beff, r;
      in_valid = 1'b1; a = ia; b = ib; op = iop; use_acc = iua; acc_wr = iaw;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         chk("accept_timeout", in_ready, 1'b1);
         return;
      end
      @(posedge clk);
      #1;
      beff = (c_acc_en && iua) ? m_acc : ib;
      r = model(ia, beff, iop);
      if (c_acc_en && iaw) m_acc = r;
      if (has_lit) chk("model_pin", r, lit);
      q.push_back('{r, cyc, lat});
   endtask

   task automatic idle();
      in_valid = 1'b0; use_acc = 1'b0; acc_wr = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("drain", q.size(), 0);
   endtask

   logic [7:0] lit_ops [0:7] = '{8'h25, 8'h52, 8'h77, 8'hCA, 8'hDA, 8'h88, 8'hAD, 8'h35};
   logic [7:0] va [0:3] = '{8'hA5, 8'hFF, 8'h00, 8'h3C};
   logic [7:0] vb [0:3] = '{8'h5A, 8'h0F, 8'hFF, 8'h3C};

   initial begin
      int start;
      // Reset state
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out", {out, zero, parity}, 10'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;

      // All eight functions on the reference operands, back to back
      for (int i = 0; i < 8; i++) send(8'h35, 8'h67, 3'(i), 1'b0, 1'b0, 1'b1, 1'b1, lit_ops[i]);
      // Zero flag
      send(8'h0F, 8'hF0, OP_AND, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      idle();
      drain();

      // Throughput: one beat per cycle
      @(posedge clk); #1;
      start = cyc;
      for (int v = 0; v < 4; v++)
         for (int o = 0; o < 8; o++) send(va[v], vb[v], 3'(o), 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("throughput", cyc - start, 32);
      idle();
      drain();

      // Backpressure: stream 4 beats into a stalled output
      @(posedge clk); #1;
      out_ready = 1'b0;
      fork
         begin
            send(8'h35, 8'h67, OP_AND, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            send(8'h35, 8'h67, OP_XOR, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            send(8'h35, 8'h67, OP_OR,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            send(8'h35, 8'h67, OP_NOT, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            idle();
         end
         begin
            repeat (5) @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_first_out", out, 8'h25);
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Accumulator: clear, then OR and XOR through the accumulator
      @(posedge clk); #1;
      acc_clr = 1'b1;
      @(posedge clk); #1;
      acc_clr = 1'b0;
      if (c_acc_en) m_acc = '0;
`ifdef LOGICU_ACC_EN
      send(8'h0F, 8'h33, OP_OR,  1'b1, 1'b1, 1'b1, 1'b1, 8'h0F);
      send(8'hFF, 8'h33, OP_XOR, 1'b1, 1'b1, 1'b1, 1'b1, 8'hF0);
`else
      send(8'h0F, 8'h33, OP_OR,  1'b1, 1'b1, 1'b1, 1'b1, 8'h3F);
      send(8'hFF, 8'h33, OP_XOR, 1'b1, 1'b1, 1'b1, 1'b1, 8'hCC);
`endif
      idle();
      drain();

      // Reset with both stages valid
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(8'h35, 8'h67, OP_AND, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      send(8'h35, 8'h67, OP_OR,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      rst = 1'b1;
      idle();
      @(negedge clk);
      chk("midrst_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      q.delete();
      m_acc = '0;
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("midrst_rel_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      send(8'h00, 8'h5A, OP_OR, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      idle();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
`default_nettype wire
